two_level_bpred: RTL

//  Parametrised two-level branch direction predictor: per-address (local) or global branch history

---
 rtl/two_level_bpred_pkg.sv | 38 +++
 rtl/two_level_bpred_if.sv | 28 ++
 rtl/two_level_bpred_pht.sv | 50 +++++
 rtl/two_level_bpred.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/two_level_bpred_pkg.sv
// Shared types and counter helpers for the two-level branch predictor.
package bp_pkg;

    typedef enum logic [1:0] {
        BP_LOCAL  = 2'd0,
        BP_GLOBAL = 2'd1,
        BP_GSHARE = 2'd2
    } bp_mode_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_e;

    // Counters are handled at the widest supported width and narrowed by the caller.
    localparam int CTR_MAX_W = 3;

    // Saturating up/down step of a width-bit counter.
    function automatic logic [CTR_MAX_W-1:0] sat_update(
        input logic [CTR_MAX_W-1:0] ctr,
        input logic                 taken,
        input int                   width
    );
        logic [CTR_MAX_W-1:0] top;
        top = CTR_MAX_W'((1 << width) - 1);
        if (taken) begin
            sat_update = (ctr == top) ? ctr : ctr + 3'd1;
        end else begin
            sat_update = (ctr == '0) ? ctr : ctr - 3'd1;
        end
    endfunction

    // Weakly-not-taken value: MSB clear, all lower bits set.
    function automatic logic [CTR_MAX_W-1:0] weak_nt(input int width);
        weak_nt = (width <= 1) ? '0 : CTR_MAX_W'((1 << (width - 1)) - 1);
    endfunction

endpackage

// File: rtl/two_level_bpred_if.sv
// Lookup, update and status signals of the branch predictor.
interface two_level_bpred_if #(
    parameter int IDX_W = 8
);
    logic             lkp_valid;
    logic [31:0]      lkp_pc;
    logic             pred_valid;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_idx;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             upd_pred;
    logic             ready;
    logic [31:0]      stat_branches;
    logic [31:0]      stat_mispred;

    modport master (
        output lkp_valid, lkp_pc, upd_valid, upd_pc, upd_idx, upd_taken, upd_pred,
        input  pred_valid, pred_taken, pred_idx, ready, stat_branches, stat_mispred
    );

    modport slave (
        input  lkp_valid, lkp_pc, upd_valid, upd_pc, upd_idx, upd_taken, upd_pred,
        output pred_valid, pred_taken, pred_idx, ready, stat_branches, stat_mispred
    );
endinterface

// File: rtl/two_level_bpred_pht.sv
// Pattern history table: registered lookup read, one write port shared by the
// init sweep and the saturating update (init has priority).
module bp_pht
    import bp_pkg::*;
#(
    parameter int IDX_W    = 8,
    parameter int CTR_BITS = 2
) (
    input  logic                clk,
    input  logic                rd_en,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [CTR_BITS-1:0] rd_ctr,
    input  logic                init_en,
    input  logic [IDX_W-1:0]    init_idx,
    input  logic                upd_en,
    input  logic [IDX_W-1:0]    upd_idx,
    input  logic                upd_taken
);
    localparam int DEPTH = 1 << IDX_W;

    logic [CTR_BITS-1:0]  mem [DEPTH];
    logic [CTR_BITS-1:0]  rd_ctr_reg;
    logic                 wr_en;
    logic [IDX_W-1:0]     wr_idx;
    logic [CTR_BITS-1:0]  wr_ctr;
    logic [CTR_MAX_W-1:0] upd_old;
    logic [CTR_MAX_W-1:0] upd_new;

    // Write mux: sweep value during init, otherwise read-modify-write of the resolved entry
    always_comb begin
        upd_old = CTR_MAX_W'(mem[upd_idx]);
        upd_new = sat_update(upd_old, upd_taken, CTR_BITS);
        wr_en   = init_en | upd_en;
        wr_idx  = init_en ? init_idx : upd_idx;
        wr_ctr  = init_en ? CTR_BITS'(weak_nt(CTR_BITS)) : CTR_BITS'(upd_new);
    end

    // Table storage; the lookup read samples the pre-write contents on a collision
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_ctr_reg <= mem[rd_idx];
        end
        if (wr_en) begin
            mem[wr_idx] <= wr_ctr;
        end
    end

    assign rd_ctr = rd_ctr_reg;

endmodule

// File: rtl/two_level_bpred.sv
// Two-level branch direction predictor: index generation, local/global history,
// table-init sequencer and resolution statistics around the PHT.
module two_level_bpred
    import bp_pkg::*;
#(
    parameter int PC_BITS   = 4,
    parameter int HIST_BITS = 4,
    parameter int BHT_BITS  = 3,
    parameter int CTR_BITS  = 2,
    parameter int MODE      = 0
) (
    input logic              clk,
    input logic              rst,
    two_level_bpred_if.slave bus
);
    localparam int               IDX_W     = PC_BITS + HIST_BITS;
    localparam int               BHT_DEPTH = 1 << BHT_BITS;
    localparam logic [IDX_W-1:0] PTR_LAST  = '1;

    bp_state_e                            state_reg, state_next;
    logic [IDX_W-1:0]                     ptr_reg, ptr_next;
    logic                                 init_en, run, upd_en, bht_upd;
    logic [BHT_DEPTH-1:0][HIST_BITS-1:0]  bht_q;
    logic [HIST_BITS-1:0]                 ghr_reg, lkp_hist;
    logic [IDX_W-1:0]                     lkp_idx;
    logic                                 pred_valid_reg, pred_run_reg;
    logic [IDX_W-1:0]                     pred_idx_reg;
    logic [CTR_BITS-1:0]                  rd_ctr;
    logic [31:0]                          stat_branches_reg, stat_mispred_reg;
    logic                                 unused_bits;

    // Phase and sweep pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= INIT;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    // Visit every PHT entry once, then switch to normal operation
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        init_en    = 1'b0;
        case (state_reg)
            INIT: begin
                init_en  = 1'b1;
                ptr_next = ptr_reg + IDX_W'(1);
                if (ptr_reg == PTR_LAST) begin
                    state_next = RUN;
                end
            end
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    assign run     = (state_reg == RUN);
    assign upd_en  = bus.upd_valid & run & ~rst;
    assign bht_upd = upd_en && (MODE == int'(BP_LOCAL));

    // Per-address history entries: cleared by the sweep, shifted on resolution
    genvar gi;
    generate
        for (gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
            logic [HIST_BITS-1:0] hist_reg;
            always_ff @(posedge clk) begin
                if (init_en && ptr_reg == IDX_W'(gi)) begin
                    hist_reg <= '0;
                end else if (bht_upd && bus.upd_pc[BHT_BITS+1:2] == BHT_BITS'(gi)) begin
                    hist_reg <= HIST_BITS'({hist_reg, bus.upd_taken});
                end
            end
            assign bht_q[gi] = hist_reg;
        end
    endgenerate

    // Global history register, shifted only on resolved branches
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_reg <= '0;
        end else if (upd_en && MODE != int'(BP_LOCAL)) begin
            ghr_reg <= HIST_BITS'({ghr_reg, bus.upd_taken});
        end
    end

    // Lookup index from the PC and the history as it stands before this cycle's update
    always_comb begin
        lkp_hist = (MODE == int'(BP_LOCAL)) ? bht_q[bus.lkp_pc[BHT_BITS+1:2]] : ghr_reg;
        if (MODE == int'(BP_GSHARE)) begin
            lkp_idx = bus.lkp_pc[IDX_W+1:2] ^ IDX_W'(ghr_reg);
        end else begin
            lkp_idx = {bus.lkp_pc[PC_BITS+1:2], lkp_hist};
        end
    end

    bp_pht #(
        .IDX_W    (IDX_W),
        .CTR_BITS (CTR_BITS)
    ) u_pht (
        .clk       (clk),
        .rd_en     (bus.lkp_valid),
        .rd_idx    (lkp_idx),
        .rd_ctr    (rd_ctr),
        .init_en   (init_en),
        .init_idx  (ptr_reg),
        .upd_en    (upd_en),
        .upd_idx   (bus.upd_idx),
        .upd_taken (bus.upd_taken)
    );

    // Prediction pipeline stage; lookups made during init never predict taken
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid_reg <= 1'b0;
            pred_run_reg   <= 1'b0;
            pred_idx_reg   <= '0;
        end else begin
            pred_valid_reg <= bus.lkp_valid;
            if (bus.lkp_valid) begin
                pred_run_reg <= run;
                pred_idx_reg <= lkp_idx;
            end
        end
    end

    // Saturating resolution statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_reg <= '0;
            stat_mispred_reg  <= '0;
        end else if (upd_en) begin
            if (stat_branches_reg != '1) begin
                stat_branches_reg <= stat_branches_reg + 32'd1;
            end
            if (bus.upd_taken != bus.upd_pred && stat_mispred_reg != '1) begin
                stat_mispred_reg <= stat_mispred_reg + 32'd1;
            end
        end
    end

    assign bus.pred_valid    = pred_valid_reg;
    assign bus.pred_taken    = pred_run_reg & rd_ctr[CTR_BITS-1];
    assign bus.pred_idx      = pred_idx_reg;
    assign bus.ready         = run;
    assign bus.stat_branches = stat_branches_reg;
    assign bus.stat_mispred  = stat_mispred_reg;

    // Only a few PC bits and the counter MSB carry meaning here
    assign unused_bits = ^{bus.lkp_pc, bus.upd_pc, rd_ctr};

endmodule
